// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_redirect_ctrl
//  Brief    : Prioritises exception / mispredict / predictor redirects onto the
//             fetch load-PC port, holding a request across fetch stalls, and
//             drives the flush pulse train, epoch bit and redirect counter.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_redirect_ctrl #(
    parameter int ADDR_WIDTH   = 26,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  exc_valid_i,
    input  logic [ADDR_WIDTH-1:0] exc_pc_i,
    input  logic                  mis_valid_i,
    input  logic [ADDR_WIDTH-1:0] mis_pc_i,
    input  logic                  pred_valid_i,
    input  logic [ADDR_WIDTH-1:0] pred_pc_i,
    output logic                  load_we_o,
    output logic [ADDR_WIDTH-1:0] load_pc_o,
    output logic                  flush_o,
    output logic                  epoch_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  redirect_cnt_o
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    localparam logic [1:0] c_CLS_PRED = 2'd0;
    localparam logic [1:0] c_CLS_MIS  = 2'd1;
    localparam logic [1:0] c_CLS_EXC  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~(ADDR_WIDTH'(3));
    localparam logic [FW-1:0]         c_FLUSH_LOAD = FW'(FLUSH_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX    = {CNT_WIDTH{1'b1}};

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_pc;
    logic [1:0]            r_pend_cls;
    logic [FW-1:0]         r_flush_cnt;
    logic                  r_epoch;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_new_valid;
    logic [1:0]            w_new_cls;
    logic [ADDR_WIDTH-1:0] w_new_pc;
    logic                  w_win_valid;
    logic [1:0]            w_win_cls;
    logic [ADDR_WIDTH-1:0] w_win_pc;
    logic [ADDR_WIDTH-1:0] w_tgt_pc;
    logic                  w_issue;
    logic                  w_hold;
    logic                  w_flush_issue;

    // Highest-class fresh request this cycle
    always_comb begin
        w_new_valid = 1'b0;
        w_new_cls   = c_CLS_PRED;
        w_new_pc    = '0;
        if (exc_valid_i) begin
            w_new_valid = 1'b1;
            w_new_cls   = c_CLS_EXC;
            w_new_pc    = exc_pc_i;
        end else if (mis_valid_i) begin
            w_new_valid = 1'b1;
            w_new_cls   = c_CLS_MIS;
            w_new_pc    = mis_pc_i;
        end else if (pred_valid_i) begin
            w_new_valid = 1'b1;
            w_new_cls   = c_CLS_PRED;
            w_new_pc    = pred_pc_i;
        end
    end

    // A held request keeps its slot unless something strictly more urgent shows up
    always_comb begin
        w_win_valid = (r_state == c_HOLD) || w_new_valid;
        w_win_cls   = w_new_cls;
        w_win_pc    = w_new_pc;
        if ((r_state == c_HOLD) && (!w_new_valid || (r_pend_cls >= w_new_cls))) begin
            w_win_cls = r_pend_cls;
            w_win_pc  = r_pend_pc;
        end
    end

    assign w_tgt_pc      = w_win_pc & c_ALIGN_MASK;
    assign w_issue       = w_win_valid && !stall_i;
    assign w_hold        = w_win_valid && stall_i;
    assign w_flush_issue = w_issue && (w_win_cls != c_CLS_PRED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_hold)   w_state_nxt = c_HOLD;
            c_HOLD: if (!stall_i) w_state_nxt = c_IDLE;
            default:              w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        load_we_o      = w_issue;
        load_pc_o      = w_issue ? w_tgt_pc : '0;
        busy_o         = (r_state == c_HOLD);
        flush_o        = (r_flush_cnt != '0);
        epoch_o        = r_epoch;
        redirect_cnt_o = r_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_pc  <= '0;
            r_pend_cls <= c_CLS_PRED;
        end else if (w_hold) begin
            r_pend_pc  <= w_tgt_pc;
            r_pend_cls <= w_win_cls;
        end else if (w_issue) begin
            r_pend_pc  <= '0;
            r_pend_cls <= c_CLS_PRED;
        end
    end

    // Flush window runs on every clock, stalled or not; a new squash restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_epoch     <= 1'b0;
        end else if (w_flush_issue) begin
            r_flush_cnt <= c_FLUSH_LOAD;
            r_epoch     <= ~r_epoch;
        end else if (r_flush_cnt != '0) begin
            r_flush_cnt <= r_flush_cnt - FW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_issue && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_redirect_ctrl
//  Brief    : Directed plus random stimulus against a cycle-level reference of
//             the redirect arbitration, flush window, epoch and counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

    localparam int AW = 26;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          ev = 1'b0, mv = 1'b0, pv = 1'b0;
    logic [AW-1:0] ep = '0, mp = '0, pp = '0;

    logic          load_we, flush, epoch, busy;
    logic [AW-1:0] load_pc;
    logic [15:0]   cnt;
    logic          s_we, s_flush, s_epoch, s_busy;
    logic [AW-1:0] s_pc;
    logic [3:0]    s_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic          m_pend_v;
    logic [1:0]    m_pend_cls;
    logic [AW-1:0] m_pend_pc;
    int            m_cyc, m_last_squash, m_squashes, m_issues;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .stall_i(stall),
        .exc_valid_i(ev), .exc_pc_i(ep), .mis_valid_i(mv), .mis_pc_i(mp),
        .pred_valid_i(pv), .pred_pc_i(pp),
        .load_we_o(load_we), .load_pc_o(load_pc), .flush_o(flush),
        .epoch_o(epoch), .busy_o(busy), .redirect_cnt_o(cnt)
    );

    fetch_redirect_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .stall_i(stall),
        .exc_valid_i(ev), .exc_pc_i(ep), .mis_valid_i(mv), .mis_pc_i(mp),
        .pred_valid_i(pv), .pred_pc_i(pp),
        .load_we_o(s_we), .load_pc_o(s_pc), .flush_o(s_flush),
        .epoch_o(s_epoch), .busy_o(s_busy), .redirect_cnt_o(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend_v      = 1'b0;
        m_pend_cls    = 2'd0;
        m_pend_pc     = '0;
        m_cyc         = 0;
        m_last_squash = -1000;
        m_squashes    = 0;
        m_issues      = 0;
    endtask

    // One clock: apply inputs, check at negedge, advance reference at posedge
    task automatic cyc(input logic st, input logic e, input logic [AW-1:0] epc,
                       input logic m, input logic [AW-1:0] mpc,
                       input logic p, input logic [AW-1:0] ppc);
        logic          v[4];
        logic [1:0]    c[4];
        logic [AW-1:0] a[4];
        int            best;
        logic          exp_we;
        logic [AW-1:0] exp_pc;
        int            age;
        stall = st; ev = e; ep = epc; mv = m; mp = mpc; pv = p; pp = ppc;
        // Candidate order doubles as tie-break: held request first
        v[0] = m_pend_v; c[0] = m_pend_cls; a[0] = m_pend_pc;
        v[1] = e;        c[1] = 2'd2;       a[1] = epc;
        v[2] = m;        c[2] = 2'd1;       a[2] = mpc;
        v[3] = p;        c[3] = 2'd0;       a[3] = ppc;
        best = -1;
        for (int i = 0; i < 4; i++)
            if (v[i] && (best < 0 || c[i] > c[best])) best = i;
        exp_we = (best >= 0) && !st;
        exp_pc = exp_we ? {a[best][AW-1:2], 2'b00} : '0;
        age    = m_cyc - m_last_squash;
        @(negedge clk);
        chk("load_we", {31'd0, load_we}, {31'd0, exp_we});
        chk("load_pc", {6'd0, load_pc}, {6'd0, exp_pc});
        chk("busy", {31'd0, busy}, {31'd0, m_pend_v});
        chk("flush", {31'd0, flush}, (age >= 1 && age <= FC) ? 32'd1 : 32'd0);
        chk("epoch", {31'd0, epoch}, 32'(m_squashes % 2));
        chk("cnt", {16'd0, cnt}, 32'(m_issues > 65535 ? 65535 : m_issues));
        chk("cnt_sat", {28'd0, s_cnt}, 32'(m_issues > 15 ? 15 : m_issues));
        if (exp_we) begin
            m_issues++;
            if (c[best] != 2'd0) begin
                m_squashes++;
                m_last_squash = m_cyc;
            end
            m_pend_v = 1'b0;
        end else if (best >= 0) begin
            m_pend_v   = 1'b1;
            m_pend_cls = c[best];
            m_pend_pc  = {a[best][AW-1:2], 2'b00};
        end
        @(posedge clk);
        #1;
        m_cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_load_we", {31'd0, load_we}, 32'd0);
        chk("rst_load_pc", {6'd0, load_pc}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_epoch", {31'd0, epoch}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Predictor redirect, no flush
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 26'h40);
        idle(2);
        // Mispredict beats predictor, flush window
        cyc(1'b0, 1'b0, '0, 1'b1, 26'h100, 1'b1, 26'h40);
        idle(4);
        // Stalled mispredict held then released
        cyc(1'b1, 1'b0, '0, 1'b1, 26'h200, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        idle(4);
        // Exception overrides held mispredict; predictor dropped
        cyc(1'b1, 1'b0, '0, 1'b1, 26'h200, 1'b0, '0);
        cyc(1'b1, 1'b1, 26'h80, 1'b0, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 26'h44);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        idle(4);
        // Back-to-back squashes extend the flush window; unaligned target
        cyc(1'b0, 1'b1, 26'h303, 1'b0, '0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, 26'h122, 1'b0, '0);
        idle(5);
        // Same-class tie keeps the held request
        cyc(1'b1, 1'b0, '0, 1'b1, 26'h500, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, 1'b1, 26'h600, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b1, 26'h700, 1'b0, '0);
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 40),
                ($urandom_range(0, 99) < 10), AW'($urandom()),
                ($urandom_range(0, 99) < 15), AW'($urandom()),
                ($urandom_range(0, 99) < 30), AW'($urandom()));
        end
        idle(3);

        // Reset while flushing and holding
        cyc(1'b0, 1'b1, 26'h900, 1'b0, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 26'h944);
        #2;
        rst = 1'b1;
        stall = 1'b0; ev = 1'b0; mv = 1'b0; pv = 1'b0;
        #1;
        chk("arst_load_we", {31'd0, load_we}, 32'd0);
        chk("arst_load_pc", {6'd0, load_pc}, 32'd0);
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_epoch", {31'd0, epoch}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cnt", {16'd0, cnt}, 32'd0);
        chk("arst_cnt_sat", {28'd0, s_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle(4);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 26'h48);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
